// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: FSM states, frame constants and the scan-code byte.
// Imported by the filter front end and the frame/FIFO top level.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    // Odd parity holds when data plus parity carries an odd number of ones.
    function automatic logic odd_ok(input ps2_byte_t b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin synchronisers, clock-line glitch filter and falling-edge strobe.
// The data bit is delayed alongside the strobe so both refer to the same sample.
import ps2_pkg::*;

module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_sys,
    input  logic clr,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic bit_val
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt;
    logic [CW-1:0] run;
    logic          differ;
    logic          change;

    assign differ = (clk_sync[1] != filt);
    assign change = differ && (run == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            run      <= '0;
            fall     <= 1'b0;
            bit_val  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            fall     <= change && filt;
            bit_val  <= dat_sync[1];
            // run counts consecutive samples that disagree with the filtered level
            if (change) begin
                filt <= clk_sync[1];
                run  <= '0;
            end else if (differ) begin
                run <= run + 1'b1;
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: frame FSM, sticky status flags and show-ahead FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames whose clock stalls for TIMEOUT_CYCLES.
import ps2_pkg::*;

module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk_sys,
    input  logic                          clr,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int BW   = $clog2(PS2_DATA_BITS);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic bit_val;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filt (
        .clk_sys (clk_sys),
        .clr     (clr),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fall    (fall),
        .bit_val (bit_val)
    );

    ps2_state_e    state, state_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    ps2_byte_t     shreg, shreg_n;
    logic          par_bit, par_n;
    logic          push_req;
    logic          perr_set;
    logic          ferr_set;
    logic          tmo_hit;
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_RX_TIMEOUT_EN
    always_ff @(posedge clk_sys) begin
        if (clr || state == ST_IDLE || fall || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Counter held at zero, so the abort never fires.
    assign tmo_cnt = '0;
`endif

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_bit;
        push_req  = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (tmo_hit) begin
            state_n  = ST_IDLE;
            ferr_set = 1'b1;
        end else if (fall) begin
            unique case (state)
                ST_IDLE: begin
                    if (!bit_val) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end
                end
                ST_DATA: begin
                    shreg_n   = {bit_val, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
                        state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_n   = bit_val;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (!odd_ok(shreg, par_bit)) begin
                        perr_set = 1'b1;
                    end else if (!bit_val) begin
                        ferr_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    ps2_byte_t     mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign ready   = (count != '0);
    assign full    = (count == CNTW'(FIFO_DEPTH));
    assign do_pop  = rd && ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push_req && (!full || do_pop);
    assign data    = ready ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !do_push) begin
                overflow <= 1'b1;
            end
            if (perr_set) begin
                parity_err <= 1'b1;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule
